// File: rtl/adder_tree_feeder.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_feeder
// Desc     : Gathers 8-bit samples into N-lane vectors for a pipelined adder
//            tree and queues the tree sums in a credit-protected output FIFO.
//            Optional partial-vector flush (in_last): ADDER_FEED_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_feeder #(
    parameter int N = 4,
    parameter int L = $clog2(N),
    parameter int D = L + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
`ifdef ADDER_FEED_FLUSH_EN
    input  logic                in_last,
`endif
    output logic                in_ready,
    output logic [N-1:0][7:0]   stage_zero,
    input  logic [7+L:0]        tree_result,
    output logic [7+L:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int c_LW = $clog2(N);
    localparam int c_OW = $clog2(D + 1);
    localparam int c_PW = (D > 1) ? $clog2(D) : 1;
    localparam logic [c_LW-1:0] c_LAST_LANE = c_LW'(N - 1);
    localparam logic [c_OW-1:0] c_DEPTH     = c_OW'(D);
    localparam logic [c_PW-1:0] c_LAST_PTR  = c_PW'(D - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_LW-1:0]        r_lane;
    logic [c_LW-1:0]        w_lane_next;
    logic [N-1:0][7:0]      r_gather;
    logic [c_OW-1:0]        r_occ;
    // One extra stage over the tree depth accounts for the stage_zero register.
    logic [L:0]             r_vpipe;
    logic [7+L:0]           r_mem [D];
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW-1:0]        r_rd_ptr;
    logic [c_OW-1:0]        r_count;
    logic                   w_accept;
    logic                   w_launch;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last;

    assign in_ready  = (r_state == S_FILL);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = r_vpipe[L];
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

`ifdef ADDER_FEED_FLUSH_EN
    assign w_last = in_last & (r_lane != c_LAST_LANE);
`else
    assign w_last = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_lane_next  = r_lane;
        w_launch     = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if ((r_lane == c_LAST_LANE) || w_last) begin
                        w_state_next = S_FULL;
                        w_lane_next  = '0;
                    end else begin
                        w_lane_next  = r_lane + c_LW'(1);
                    end
                end
            end
            S_FULL: begin
                // Credit check uses the current occupancy; a same-cycle pop does not help.
                if (r_occ < c_DEPTH) begin
                    w_launch     = 1'b1;
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FILL;
            r_lane     <= '0;
            r_gather   <= '0;
            stage_zero <= '0;
            r_vpipe    <= '0;
            r_occ      <= '0;
        end else begin
            r_state <= w_state_next;
            r_lane  <= w_lane_next;
            r_vpipe <= {r_vpipe[L-1:0], w_launch};
            r_occ   <= r_occ + c_OW'(w_launch) - c_OW'(w_pop);
            if (w_accept) begin
                r_gather[r_lane] <= in_data;
`ifdef ADDER_FEED_FLUSH_EN
                if (w_last) begin
                    for (int i = 0; i < N; i++) begin
                        if (c_LW'(i) > r_lane) begin
                            r_gather[i] <= '0;
                        end
                    end
                end
`endif
            end
            if (w_launch) begin
                stage_zero <= r_gather;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PW'(1);
            end
            r_count <= r_count + c_OW'(w_push) - c_OW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tree_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_feeder
// Desc     : Self-checking bench for adder_tree_feeder (N=4) with a behavioural
//            adder-tree model and a sum scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_feeder;

    localparam int N = 4;
    localparam int L = 2;
`ifdef ADDER_FEED_FLUSH_EN
    localparam bit c_FLUSH = 1'b1;
`else
    localparam bit c_FLUSH = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][7:0] s;
        logic [9:0]      sum;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               last_drv;
    logic               in_ready;
    logic [N-1:0][7:0]  stage_zero;
    logic [9:0]         tree_result;
    logic [9:0]         out_data;
    logic               out_valid;
    logic               out_ready;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 cyc      = 0;
    int                 pop_cnt  = 0;
    int                 n_acc    = 0;
    int                 tb_k     = 0;
    int                 tb_acc   = 0;
    bit                 drv_done = 1'b1;
    logic [9:0]         exp_q [$];
    int                 pop_times [$];
    logic [9:0]         tree_p [L];
    vec_t               tbl [5];

    always #5 clk = ~clk;

    adder_tree_feeder #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
`ifdef ADDER_FEED_FLUSH_EN
        .in_last     (last_drv),
`endif
        .in_ready    (in_ready),
        .stage_zero  (stage_zero),
        .tree_result (tree_result),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    // Behavioural L-stage tree fed by the registered stage_zero vector.
    always @(posedge clk) begin
        tree_p[0] <= 10'(stage_zero[0]) + 10'(stage_zero[1]) + 10'(stage_zero[2]) + 10'(stage_zero[3]);
        for (int i = 1; i < L; i++) tree_p[i] <= tree_p[i-1];
    end
    assign tree_result = tree_p[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sum", {22'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("scoreboard_sum", {22'd0, out_data}, {22'd0, exp_q.pop_front()});
            end
            pop_cnt++;
            pop_times.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [7:0] d, input logic last);
        int guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        last_drv = last;
        @(negedge clk);
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                check("send_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        n_acc++;
        tb_acc += int'(d);
        if (tb_k == N - 1 || (last_drv && c_FLUSH)) begin
            exp_q.push_back(10'(tb_acc));
            tb_acc = 0;
            tb_k   = 0;
        end else begin
            tb_k++;
        end
        in_valid = 1'b0;
        last_drv = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || !drv_done) && g < 400) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] third;

        tbl[0] = '{s: {8'd4,   8'd3,   8'd2,   8'd1},   sum: 10'd10};
        tbl[1] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, sum: 10'd1020};
        tbl[2] = '{s: {8'd0,   8'd0,   8'd0,   8'd0},   sum: 10'd0};
        tbl[3] = '{s: {8'd7,   8'd64,  8'd1,   8'd128}, sum: 10'd200};
        tbl[4] = '{s: {8'd40,  8'd30,  8'd20,  8'd10},  sum: 10'd100};

        rst       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        last_drv  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   {31'd0, in_ready},  32'd1);
        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_out_data",   {22'd0, out_data},  32'd0);
        check("rst_stage_zero", stage_zero,         32'd0);
        step();
        rst = 1'b1;

        // Isolated vectors: sum, latency from 4th accept, and held lane vector.
        for (int i = 0; i < 5; i++) begin
            step();
            for (int k = 0; k < N; k++) send(tbl[i].s[k], 1'b0);
            wait_out(lat);
            check("vec_latency",    lat,                   32'd5);
            check("vec_sum",        {22'd0, out_data},     {22'd0, tbl[i].sum});
            check("vec_stage_zero", stage_zero,            tbl[i].s);
        end
        wait_drain();

        // Back-to-back stream: one vector per N+1 cycles.
        pop_times.delete();
        for (int i = 0; i < 12; i++) send(8'(11 + i), 1'b0);
        wait_drain();
        check("stream_pops", pop_times.size(), 32'd3);
        if (pop_times.size() == 3) begin
            check("stream_period0", pop_times[1] - pop_times[0], 32'd5);
            check("stream_period1", pop_times[2] - pop_times[1], 32'd5);
        end

        // Backpressure: credit limits the tree to D outstanding sums.
        step();
        out_ready = 1'b0;
        pop_cnt   = 0;
        n_acc     = 0;
        drv_done  = 1'b0;
        for (int k = 0; k < N; k++) third[k*8 +: 8] = 8'((8 + k) * 13 + 5);
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'(i * 13 + 5), 1'b0);
                drv_done = 1'b1;
            end
        join_none
        repeat (45) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_stall", {31'd0, in_ready},  32'd0);
        check("bp_accepted",       n_acc,              32'd16);
        check("bp_out_valid",      {31'd0, out_valid}, 32'd1);
        check("bp_stage_zero",     stage_zero,         third);
        check("bp_no_pops",        pop_cnt,            32'd0);
        step();
        out_ready = 1'b1;
        wait_drain();
        check("bp_pops", pop_cnt, 32'd5);

`ifdef ADDER_FEED_FLUSH_EN
        step();
        send(8'd7, 1'b0);
        send(8'd9, 1'b1);
        wait_out(lat);
        check("flush_stage_zero", stage_zero,        32'h0000_0907);
        check("flush_sum",        {22'd0, out_data}, 32'd16);
        step();
        for (int k = 0; k < N; k++) send(8'(k + 1), 1'b0);
        wait_out(lat);
        check("flush_next_stage_zero", stage_zero,        32'h0403_0201);
        check("flush_next_sum",        {22'd0, out_data}, 32'd10);
        wait_drain();
`endif

        // Reset with two vectors in flight: nothing stale may emerge.
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(50 + i), 1'b0);
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        tb_k   = 0;
        tb_acc = 0;
        @(negedge clk);
        check("midrst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("midrst_stage_zero", stage_zero,         32'd0);
        check("midrst_in_ready",   {31'd0, in_ready},  32'd1);
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        pop_cnt   = 0;
        @(negedge clk);
        check("postrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (15) step();
        check("postrst_no_stale", pop_cnt, 32'd0);

        for (int k = 0; k < N; k++) send(8'(5 + k), 1'b0);
        wait_out(lat);
        check("recover_sum", {22'd0, out_data}, 32'd26);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
